// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction sequencer: FSM state encoding and response status codes.
// No logic lives here.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_EVAL      = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_RESP      = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_NACK    = 2'd1,
    RSP_TIMEOUT = 2'd2
  } rsp_status_t;

endpackage

// File: rtl/i2c_seq_timer.sv
// Bus-hang watchdog: counts enabled cycles from a clear and flags TIMEOUT_CYCLES-1.
// Expired is combinational from the count; the counter holds once it gets there.
module i2c_seq_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk_400,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Command front-end for the I2C byte master: one command in, one response out, with NACK retry and timeout.
// Start pulse one cycle after accept; a new command is refused until the response has been taken.
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 2
) (
  input  logic        clk_400,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic        cmd_two_byte,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_nbytes,
  output logic [1:0]  rsp_status,
  output logic [7:0]  nack_cnt,
  output logic        m_start_txn,
  output logic        m_rw,
  output logic [6:0]  m_sub_addr,
  output logic [7:0]  m_data_in,
  output logic        m_next_byte,
  input  logic [7:0]  m_data_out,
  input  logic        m_data_ready,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic        m_ack_error
);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  seq_state_t    state_q, state_d;
  rsp_status_t   rsp_status_q, rsp_status_d;
  logic          m_rw_q, m_rw_d;
  logic [6:0]    m_sub_addr_q, m_sub_addr_d;
  logic [7:0]    m_data_in_q, m_data_in_d;
  logic          m_next_byte_q, m_next_byte_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_nbytes_q, rsp_nbytes_d;
  logic [7:0]    nack_cnt_q, nack_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          nack_lat_q, nack_lat_d;
  logic          done_q, done_d;

  logic tmr_clr, tmr_en, tmr_expired, timed_out, done_edge;

  assign cmd_ready   = (state_q == ST_IDLE) & rst_n;
  assign m_start_txn = (state_q == ST_ISSUE);
  assign m_rw        = m_rw_q;
  assign m_sub_addr  = m_sub_addr_q;
  assign m_data_in   = m_data_in_q;
  assign m_next_byte = m_next_byte_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_nbytes  = rsp_nbytes_q;
  assign rsp_status  = rsp_status_q;
  assign nack_cnt    = nack_cnt_q;

  // The master may hold done for several cycles; only its rising edge ends an attempt.
  assign done_edge = m_done & ~done_q;
  assign tmr_en    = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
  assign timed_out = tmr_en & tmr_expired;

  i2c_seq_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_400 (clk_400),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    rsp_status_d  = rsp_status_q;
    m_rw_d        = m_rw_q;
    m_sub_addr_d  = m_sub_addr_q;
    m_data_in_d   = m_data_in_q;
    m_next_byte_d = m_next_byte_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_nbytes_d  = rsp_nbytes_q;
    nack_cnt_d    = nack_cnt_q;
    retry_d       = retry_q;
    nack_lat_d    = nack_lat_q;
    done_d        = m_done;
    tmr_clr       = 1'b0;

    if (tmr_en && m_ack_error) begin
      nack_lat_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          m_rw_d        = cmd_rw;
          m_sub_addr_d  = cmd_addr;
          m_data_in_d   = cmd_wdata;
          m_next_byte_d = cmd_two_byte & cmd_rw;
          rsp_data_d    = '0;
          rsp_nbytes_d  = '0;
          rsp_status_d  = RSP_OK;
          nack_lat_d    = 1'b0;
          retry_d       = '0;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (timed_out) begin
          rsp_status_d = RSP_TIMEOUT;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else if (m_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A byte arriving with the done edge is still captured before evaluation.
        if (m_data_ready && (rsp_nbytes_q < 2'd2)) begin
          if (rsp_nbytes_q[0]) begin
            rsp_data_d[15:8] = m_data_out;
          end else begin
            rsp_data_d[7:0] = m_data_out;
          end
          rsp_nbytes_d = rsp_nbytes_q + 2'd1;
        end
        if (timed_out) begin
          rsp_status_d = RSP_TIMEOUT;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else if (done_edge) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (!nack_lat_q) begin
          rsp_status_d = RSP_OK;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          nack_cnt_d = (nack_cnt_q == 8'hFF) ? nack_cnt_q : nack_cnt_q + 8'd1;
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d      = retry_q + RW'(1);
            nack_lat_d   = 1'b0;
            rsp_data_d   = '0;
            rsp_nbytes_d = '0;
            state_d      = ST_DRAIN;
          end else begin
            rsp_status_d = RSP_NACK;
            rsp_valid_d  = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_DRAIN: begin
        if (!m_busy && !m_done) begin
          state_d = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rsp_status_q  <= RSP_OK;
      m_rw_q        <= 1'b0;
      m_sub_addr_q  <= '0;
      m_data_in_q   <= '0;
      m_next_byte_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_nbytes_q  <= '0;
      nack_cnt_q    <= '0;
      retry_q       <= '0;
      nack_lat_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rsp_status_q  <= rsp_status_d;
      m_rw_q        <= m_rw_d;
      m_sub_addr_q  <= m_sub_addr_d;
      m_data_in_q   <= m_data_in_d;
      m_next_byte_q <= m_next_byte_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_nbytes_q  <= rsp_nbytes_d;
      nack_cnt_q    <= nack_cnt_d;
      retry_q       <= retry_d;
      nack_lat_q    <= nack_lat_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: behavioural byte-master model, directed table, randomized
// commands scored against a transaction-level model, plus reset and backpressure sequences.
module tb_i2c_txn_sequencer;
  localparam int TO = 16;
  localparam int MR = 2;

  logic        clk_400 = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_rw, cmd_two_byte;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_nbytes, rsp_status;
  logic [7:0]  nack_cnt;
  logic        m_start_txn, m_rw, m_next_byte;
  logic [6:0]  m_sub_addr;
  logic [7:0]  m_data_in, m_data_out;
  logic        m_data_ready, m_busy, m_done, m_ack_error;

  i2c_txn_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .clk_400(clk_400), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_two_byte(cmd_two_byte),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_nbytes(rsp_nbytes), .rsp_status(rsp_status), .nack_cnt(nack_cnt),
    .m_start_txn(m_start_txn), .m_rw(m_rw), .m_sub_addr(m_sub_addr), .m_data_in(m_data_in),
    .m_next_byte(m_next_byte), .m_data_out(m_data_out), .m_data_ready(m_data_ready),
    .m_busy(m_busy), .m_done(m_done), .m_ack_error(m_ack_error)
  );

  always #5 clk_400 = ~clk_400;

  int cyc = 0;
  int start_cnt = 0;
  always @(posedge clk_400) cyc <= cyc + 1;
  always @(negedge clk_400) if (m_start_txn) start_cnt <= start_cnt + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behaviour plan for the master model, set by the stimulus before each command.
  logic       p_stuck = 1'b0, p_hang = 1'b0, p_coin = 1'b0;
  int         p_nacks = 0, p_nstr = 0, p_base = 0, m_total = 0;
  logic [7:0] pb [3];

  initial begin : master
    m_busy = 0; m_done = 0; m_ack_error = 0; m_data_ready = 0; m_data_out = 0;
    forever begin
      @(negedge clk_400);
      if (rst_n && m_start_txn) begin
        m_total++;
        if (p_hang) begin
          @(negedge clk_400); m_busy = 1;
          wait (!rst_n);
          m_busy = 0;
        end else if (!p_stuck) begin
          @(negedge clk_400); m_busy = 1;
          @(negedge clk_400);
          if (m_total - p_base <= p_nacks) begin
            m_ack_error = 1;
            @(negedge clk_400); m_ack_error = 0;
          end else begin
            @(negedge clk_400);
            for (int i = 0; i < p_nstr; i++) begin
              m_data_out = pb[i]; m_data_ready = 1;
              if (p_coin && i == p_nstr - 1) break;
              @(negedge clk_400); m_data_ready = 0;
              @(negedge clk_400);
            end
          end
          m_done = 1; m_busy = 0;
          @(negedge clk_400); m_data_ready = 0;
          @(negedge clk_400); m_done = 0;
        end
      end
    end
  end

  typedef struct {
    logic rw; logic [6:0] addr; logic [7:0] wdata; logic two;
    int nacks; int nstr; logic [7:0] b0; logic [7:0] b1; logic [7:0] b2;
    logic coin; logic stuck; int hold;
    logic [1:0] e_st; logic [1:0] e_nb; logic [15:0] e_data; int e_starts; int e_nack;
  } vec_t;

  typedef struct {
    logic [1:0] st; logic [1:0] nb; logic [15:0] data;
    int starts; int nack; int lat; logic mok; logic hold_ok;
  } obs_t;

  // Transaction-level reference: outcome follows only from NACK count, strobes and hang.
  task automatic model(inout vec_t v, inout int acc_nack);
    int k;
    v.e_data = 16'h0; v.e_nb = 2'd0;
    if (v.stuck) begin
      v.e_st = 2'd2; v.e_starts = 1;
    end else if (v.nacks > MR) begin
      v.e_st = 2'd1; v.e_starts = MR + 1; acc_nack += MR + 1;
    end else begin
      v.e_st = 2'd0; v.e_starts = v.nacks + 1; acc_nack += v.nacks;
      k = (v.nstr > 2) ? 2 : v.nstr;
      v.e_nb = 2'(k);
      if (k > 0) v.e_data[7:0] = v.b0;
      if (k > 1) v.e_data[15:8] = v.b1;
    end
    if (acc_nack > 255) acc_nack = 255;
    v.e_nack = acc_nack;
  endtask

  task automatic run_txn(input vec_t v, output obs_t o);
    int n; int acc; int sbase;
    p_nacks = v.nacks; p_nstr = v.nstr; p_coin = v.coin; p_stuck = v.stuck;
    pb[0] = v.b0; pb[1] = v.b1; pb[2] = v.b2;
    p_base = m_total; sbase = start_cnt;
    n = 0;
    @(negedge clk_400);
    while (!cmd_ready && n < 100) begin @(negedge clk_400); n++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1; cmd_rw = v.rw; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_two_byte = v.two;
    @(posedge clk_400); #1;
    acc = cyc; cmd_valid = 0;
    n = 0;
    @(negedge clk_400);
    while (!rsp_valid && n < 300) begin @(negedge clk_400); n++; end
    check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    o.lat = cyc - acc; o.st = rsp_status; o.nb = rsp_nbytes; o.data = rsp_data;
    o.starts = start_cnt - sbase; o.nack = int'(nack_cnt);
    o.mok = (m_rw === v.rw) && (m_sub_addr === v.addr) && (m_data_in === v.wdata) &&
            (m_next_byte === (v.two & v.rw));
    o.hold_ok = 1'b1;
    repeat (v.hold) begin
      @(negedge clk_400);
      if (rsp_valid !== 1'b1 || rsp_data !== o.data || rsp_nbytes !== o.nb ||
          rsp_status !== o.st || cmd_ready !== 1'b0) o.hold_ok = 1'b0;
    end
    @(negedge clk_400); rsp_ready = 1;
    @(posedge clk_400); #1;
    rsp_ready = 0;
    check("rsp_release", {30'd0, rsp_valid, cmd_ready}, 32'd1);
  endtask

  task automatic compare_obs(input string tag, input vec_t v, input obs_t o);
    check($sformatf("%s status", tag), 32'(o.st), 32'(v.e_st));
    check($sformatf("%s nbytes", tag), 32'(o.nb), 32'(v.e_nb));
    check($sformatf("%s data", tag), 32'(o.data), 32'(v.e_data));
    check($sformatf("%s starts", tag), 32'(o.starts), 32'(v.e_starts));
    check($sformatf("%s nack_cnt", tag), 32'(o.nack), 32'(v.e_nack));
    check($sformatf("%s m_outputs", tag), 32'(o.mok), 32'd1);
    if (v.stuck) check($sformatf("%s timeout_latency", tag), 32'(o.lat), 32'(TO + 1));
    if (v.hold > 0) check($sformatf("%s hold_stable", tag), 32'(o.hold_ok), 32'd1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[8];
  vec_t v;
  obs_t o;
  int   acc_nack;
  int   n;
  logic ok;

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_rw = 0; cmd_addr = 0; cmd_wdata = 0; cmd_two_byte = 0;
    rsp_ready = 0;
    //           rw    addr   wdata  two  nk nstr b0     b1     b2     coin stuck hold st    nb    data       starts nack
    tbl[0] = '{1'b0, 7'h50, 8'hA5, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0,  2'd0, 2'd0, 16'h0000, 1, 0};
    tbl[1] = '{1'b1, 7'h2C, 8'h00, 1'b1, 0, 2, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 10, 2'd0, 2'd2, 16'h3412, 1, 0};
    tbl[2] = '{1'b0, 7'h3A, 8'h5C, 1'b0, 9, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0,  2'd1, 2'd0, 16'h0000, 3, 3};
    tbl[3] = '{1'b1, 7'h51, 8'hFF, 1'b0, 1, 1, 8'h77, 8'h00, 8'h00, 1'b0, 1'b0, 0,  2'd0, 2'd1, 16'h0077, 2, 4};
    tbl[4] = '{1'b1, 7'h7F, 8'h00, 1'b1, 0, 3, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0, 0,  2'd0, 2'd2, 16'hBBAA, 1, 4};
    tbl[5] = '{1'b1, 7'h01, 8'h00, 1'b0, 0, 1, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 0,  2'd0, 2'd1, 16'h005A, 1, 4};
    tbl[6] = '{1'b1, 7'h40, 8'h11, 1'b1, 2, 2, 8'hDE, 8'hAD, 8'h00, 1'b0, 1'b0, 0,  2'd0, 2'd2, 16'hADDE, 3, 6};
    tbl[7] = '{1'b0, 7'h22, 8'h33, 1'b0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0,  2'd2, 2'd0, 16'h0000, 1, 6};

    repeat (3) @(negedge clk_400);
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset rsp", {11'd0, rsp_valid, rsp_data, rsp_nbytes, rsp_status}, 32'd0);
    check("reset m_out", {14'd0, m_start_txn, m_rw, m_sub_addr, m_data_in, m_next_byte}, 32'd0);
    check("reset nack_cnt", 32'(nack_cnt), 32'd0);
    rst_n = 1;
    @(negedge clk_400);
    check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], o);
      compare_obs($sformatf("dir%0d", i), tbl[i], o);
    end
    acc_nack = tbl[7].e_nack;

    for (int i = 0; i < 150; i++) begin
      v.rw = 1'($urandom_range(0, 1)); v.addr = 7'($urandom); v.wdata = 8'($urandom);
      v.two = 1'($urandom_range(0, 1)); v.nacks = $urandom_range(0, 5);
      v.nstr = v.rw ? $urandom_range(0, 3) : 0;
      v.b0 = 8'($urandom); v.b1 = 8'($urandom); v.b2 = 8'($urandom);
      v.coin = 1'($urandom_range(0, 1)); v.stuck = ($urandom_range(0, 9) == 0);
      v.hold = $urandom_range(0, 3);
      model(v, acc_nack);
      run_txn(v, o);
      compare_obs($sformatf("rnd%0d", i), v, o);
    end

    // Reset while the master is mid-transfer.
    p_hang = 1; p_stuck = 0;
    @(negedge clk_400);
    cmd_valid = 1; cmd_rw = 1; cmd_addr = 7'h33; cmd_wdata = 8'h44; cmd_two_byte = 1;
    @(posedge clk_400); #1;
    cmd_valid = 0;
    n = 0;
    while (!m_busy && n < 50) begin @(negedge clk_400); n++; end
    check("hang m_busy", 32'(m_busy), 32'd1);
    repeat (2) @(negedge clk_400);
    rst_n = 0; #1;
    check("midrst rsp", {11'd0, rsp_valid, rsp_data, rsp_nbytes, rsp_status}, 32'd0);
    check("midrst m_out", {14'd0, m_start_txn, m_rw, m_sub_addr, m_data_in, m_next_byte}, 32'd0);
    check("midrst nack_cnt", 32'(nack_cnt), 32'd0);
    check("midrst cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk_400);
    rst_n = 1; p_hang = 0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk_400);
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
    end
    check("post-midrst idle", 32'(ok), 32'd1);
    v = '{1'b0, 7'h10, 8'h20, 1'b0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0,
          2'd0, 2'd0, 16'h0000, 1, 0};
    run_txn(v, o);
    compare_obs("after_rst", v, o);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
